q2_lcd_ctrl: RTL and testbench



---
 rtl/q2_lcd_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_q2_lcd_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/q2_lcd_ctrl.sv
// q2_lcd_ctrl: write FIFO feeding an HD44780-style 8-bit LCD timing FSM with column wrap.
// Optional power-on init sequence enabled by defining Q2_LCD_INIT_EN. Rev 1.0
`default_nettype none

module q2_lcd_ctrl #(
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int DEPTH      = 8,
  parameter int E_CYCLES   = 4,
  parameter int SHORT_WAIT = 50,
  parameter int LONG_WAIT  = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [11:0] dbus,
  output logic        busy,
  output logic        overflow,
  output logic        lcd_rs,
  output logic        lcd_e,
  output logic [7:0]  lcd_d
);

`ifdef Q2_LCD_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  localparam int AW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int MAXA = (LONG_WAIT > SHORT_WAIT) ? LONG_WAIT : SHORT_WAIT;
  localparam int MAXW = (MAXA > E_CYCLES) ? MAXA : E_CYCLES;
  localparam int CW   = $clog2(MAXW + 1);

  localparam logic [AW:0]   C_FULL   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] C_E      = CW'(E_CYCLES - 1);
  localparam logic [CW-1:0] C_SHORT  = CW'(SHORT_WAIT - 1);
  localparam logic [CW-1:0] C_LONG   = CW'(LONG_WAIT - 1);
  localparam logic [6:0]    C_END0   = 7'(COLS - 1);
  localparam logic [6:0]    C_END1   = 7'(64 + COLS - 1);
  localparam logic [2:0]    C_INIT_N = 3'd4;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_WAIT  = 3'd4,
    S_WRAP  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          arm_q, arm_d;
  logic [6:0]    addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_q, long_d;
  logic          wrap_q, wrap_d;
  logic          wrap_hi_q, wrap_hi_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          lcd_e_q, lcd_e_d;
  logic [7:0]    lcd_d_q, lcd_d_d;
  logic          in_init_q, in_init_d;
  logic [2:0]    init_idx_q, init_idx_d;

  logic          full, empty, push, pop;
  logic [8:0]    head;
  logic          unused_bits;

  assign unused_bits = ^dbus[11:9];

  assign full  = (count_q == C_FULL);
  assign empty = (count_q == '0);
  assign push  = wr && !full;
  assign head  = mem_q[rptr_q];

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Non-printable characters are shown as '?'
  function automatic logic [7:0] filt(input logic [7:0] b);
    return (b < 8'h20 || b > 8'h7E) ? 8'h3F : b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= dbus[8:0];
  end

  // Full test uses the pre-edge count, so a same-cycle pop never frees room
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_EN ? S_INIT : S_IDLE;
      arm_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      long_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_hi_q  <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_d_q    <= 8'h00;
      in_init_q  <= INIT_EN;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      long_q     <= long_d;
      wrap_q     <= wrap_d;
      wrap_hi_q  <= wrap_hi_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_e_q    <= lcd_e_d;
      lcd_d_q    <= lcd_d_d;
      in_init_q  <= in_init_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arm_d      = arm_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    long_d     = long_q;
    wrap_d     = wrap_q;
    wrap_hi_d  = wrap_hi_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_e_d    = lcd_e_q;
    lcd_d_d    = lcd_d_q;
    in_init_d  = in_init_q;
    init_idx_d = init_idx_q;
    pop        = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_idx_q == C_INIT_N) begin
          in_init_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          lcd_rs_d   = 1'b0;
          lcd_d_d    = init_cmd(init_idx_q);
          long_d     = (init_idx_q == 3'd3);
          if (init_idx_q == 3'd3) addr_d = '0;
          init_idx_d = init_idx_q + 1'b1;
          state_d    = S_SETUP;
        end
      end

      // One armed cycle before the pop lets the head settle; lcd_d updates on the pop edge
      S_IDLE: begin
        if (!arm_q) begin
          if (!empty) arm_d = 1'b1;
        end else begin
          arm_d = 1'b0;
          pop   = 1'b1;
          if (head[8]) begin
            if (head[7]) begin
              lcd_rs_d = 1'b0;
              lcd_d_d  = {1'b1, head[6:0]};
              addr_d   = head[6:0];
              long_d   = 1'b0;
              state_d  = S_SETUP;
            end else if (head[0]) begin
              lcd_rs_d = 1'b0;
              lcd_d_d  = 8'h01;
              addr_d   = '0;
              long_d   = 1'b1;
              state_d  = S_SETUP;
            end
          end else begin
            lcd_rs_d = 1'b1;
            lcd_d_d  = filt(head[7:0]);
            addr_d   = addr_q + 1'b1;
            long_d   = 1'b0;
            state_d  = S_SETUP;
            if (addr_q == C_END0 || (ROWS == 2 && addr_q == C_END1)) begin
              wrap_d    = 1'b1;
              wrap_hi_d = (ROWS == 2) && (addr_q == C_END0);
            end
          end
        end
      end

      S_SETUP: begin
        lcd_e_d = 1'b1;
        cnt_d   = C_E;
        state_d = S_PULSE;
      end

      S_PULSE: begin
        if (cnt_q == '0) begin
          lcd_e_d = 1'b0;
          cnt_d   = long_q ? C_LONG : C_SHORT;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          if (wrap_q)         state_d = S_WRAP;
          else if (in_init_q) state_d = S_INIT;
          else                state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WRAP: begin
        wrap_d   = 1'b0;
        lcd_rs_d = 1'b0;
        lcd_d_d  = wrap_hi_q ? 8'hC0 : 8'h80;
        addr_d   = wrap_hi_q ? 7'h40 : 7'h00;
        long_d   = 1'b0;
        state_d  = S_SETUP;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = !empty || (state_q != S_IDLE);
  assign overflow = overflow_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_e    = lcd_e_q;
  assign lcd_d    = lcd_d_q;

endmodule

`default_nettype wire

// File: tb/tb_q2_lcd_ctrl.sv
// Scoreboard bench for q2_lcd_ctrl: expected LCD cycles queued at write time, checked on lcd_e rise.
`default_nettype none

module tb_q2_lcd_ctrl;

  localparam int COLS = 16, ROWS = 2, DEPTH = 8, E_CYCLES = 4;
  localparam int SHORT_WAIT = 50, LONG_WAIT = 2000;

  logic clk = 1'b0, rst = 1'b1, wr = 1'b0;
  logic [11:0] dbus = '0;
  logic busy, overflow, lcd_rs, lcd_e;
  logic [7:0] lcd_d;

  int n_tests = 0, n_fail = 0;
  logic [8:0] exp_q[$];
  logic e_prev = 1'b0;

  q2_lcd_ctrl #(.COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH), .E_CYCLES(E_CYCLES),
                .SHORT_WAIT(SHORT_WAIT), .LONG_WAIT(LONG_WAIT)) dut (
    .clk(clk), .rst(rst), .wr(wr), .dbus(dbus), .busy(busy), .overflow(overflow),
    .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising lcd_e must match the oldest expected {rs,d}
  always @(negedge clk) begin
    if (!rst && lcd_e && !e_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_lcd_cycle", {23'd0, lcd_rs, lcd_d}, 32'h1FF);
      end else begin
        check("lcd_cycle", {23'd0, lcd_rs, lcd_d}, {23'd0, exp_q.pop_front()});
      end
    end
    e_prev = rst ? 1'b0 : lcd_e;
  end

  task automatic expect_cyc(input logic rs, input logic [7:0] d);
    exp_q.push_back({rs, d});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check(name, 1, 0);
  endtask

  task automatic wait_e(input logic lvl, input string name);
    int n = 0;
    while (lcd_e !== lvl && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (lcd_e !== lvl) check(name, lcd_e, lvl);
  endtask

  task automatic wr_word(input logic [11:0] w);
    @(negedge clk);
    wr = 1'b1;
    dbus = w;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_reset(input logic wr_during);
    @(negedge clk);
    rst = 1'b1;
    wr = wr_during;
    dbus = 12'h041;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr = 1'b0;
`ifdef Q2_LCD_INIT_EN
    expect_cyc(1'b0, 8'h38);
    expect_cyc(1'b0, 8'h0C);
    expect_cyc(1'b0, 8'h06);
    expect_cyc(1'b0, 8'h01);
    wait_idle("init_timeout");
`endif
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_d", lcd_d, 8'h00);
    check("rst_overflow", overflow, 0);
    check("rst_addr", dut.addr_q, 0);
`ifndef Q2_LCD_INIT_EN
    check("rst_busy", busy, 0);
`endif
    do_reset(1'b1);
`ifndef Q2_LCD_INIT_EN
    @(negedge clk);
    check("wr_in_reset_ignored", busy, 0);
`endif

    // Single data write: latency and pulse timing
    expect_cyc(1'b1, 8'h41);
    @(negedge clk); wr = 1'b1; dbus = 12'h041;
    @(negedge clk); wr = 1'b0;
    @(negedge clk);
    check("lat_e_low_n1", lcd_e, 0);
    check("lat_busy_n1", busy, 1);
    @(negedge clk);
    check("lat_rs_n2", lcd_rs, 1);
    check("lat_d_n2", lcd_d, 8'h41);
    check("lat_e_low_n2", lcd_e, 0);
    @(negedge clk);
    check("lat_e_rise_n3", lcd_e, 1);
    repeat (E_CYCLES - 1) @(negedge clk);
    check("lat_e_last", lcd_e, 1);
    @(negedge clk);
    check("lat_e_fall", lcd_e, 0);
    check("lat_d_hold_wait", lcd_d, 8'h41);
    check("lat_busy_wait", busy, 1);
    repeat (SHORT_WAIT - 1) @(negedge clk);
    check("busy_end_wait", busy, 1);
    @(negedge clk);
    check("busy_low_after_wait", busy, 0);
    check("addr_after_data", dut.addr_q, 1);

    // Clear then data: long wait between cycles
    do_reset(1'b0);
    expect_cyc(1'b0, 8'h01);
    expect_cyc(1'b1, 8'h5A);
    wr_word(12'h101);
    wr_word(12'h05A);
    wait_e(1'b1, "clear_rise_timeout");
    wait_e(1'b0, "clear_fall_timeout");
    n = 0;
    while (lcd_e == 1'b0 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("clear_gap_cycles", n, LONG_WAIT + 3);
    wait_idle("clear_idle_timeout");
    check("addr_after_clear_data", dut.addr_q, 1);

    // Non-printable substitution
    do_reset(1'b0);
    expect_cyc(1'b1, 8'h3F);
    expect_cyc(1'b1, 8'h3F);
    expect_cyc(1'b1, 8'h3F);
    wr_word(12'h0C8);
    wr_word(12'h07F);
    wr_word(12'h01F);
    wait_idle("filter_timeout");

    // Row 0 end wraps to row 1, row 1 end wraps to row 0, discard entry, no wrap mid-row
    do_reset(1'b0);
    expect_cyc(1'b0, 8'h8F);
    expect_cyc(1'b1, 8'h41);
    expect_cyc(1'b0, 8'hC0);
    wr_word(12'h18F);
    wr_word(12'h041);
    wait_idle("wrap0_timeout");
    check("addr_wrap_row1", dut.addr_q, 7'h40);
    expect_cyc(1'b0, 8'hCF);
    expect_cyc(1'b1, 8'h42);
    expect_cyc(1'b0, 8'h80);
    wr_word(12'h1CF);
    wr_word(12'h042);
    wait_idle("wrap1_timeout");
    check("addr_wrap_row0", dut.addr_q, 7'h00);
    expect_cyc(1'b0, 8'h85);
    expect_cyc(1'b1, 8'h4A);
    wr_word(12'h185);
    wr_word(12'h100);
    wr_word(12'h04A);
    wait_idle("nowrap_timeout");
    check("addr_nowrap", dut.addr_q, 7'h06);

    // Overflow: DEPTH+2 back-to-back writes from idle
    do_reset(1'b0);
    @(negedge clk);
    wr = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      dbus = 12'h030 + 12'(i);
      if (i <= DEPTH) expect_cyc(1'b1, 8'h30 + 8'(i));
      @(negedge clk);
    end
    wr = 1'b0;
    check("overflow_set", overflow, 1);
    wait_idle("overflow_timeout");
    check("overflow_sticky", overflow, 1);
    do_reset(1'b0);
    check("overflow_cleared", overflow, 0);

    // Reset mid-pulse drops lcd_e and loses the entry
    expect_cyc(1'b1, 8'h55);
    wr_word(12'h055);
    wait_e(1'b1, "midpulse_rise_timeout");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midpulse_e_drop", lcd_e, 0);
    check("midpulse_d_clr", lcd_d, 8'h00);
    rst = 1'b0;
`ifdef Q2_LCD_INIT_EN
    expect_cyc(1'b0, 8'h38);
    expect_cyc(1'b0, 8'h0C);
    expect_cyc(1'b0, 8'h06);
    expect_cyc(1'b0, 8'h01);
    expect_cyc(1'b1, 8'h49);
    wr_word(12'h049);
    wait_idle("init_write_timeout");
`else
    @(negedge clk);
    check("midpulse_busy", busy, 0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
